// File: rtl/hsadc_packetizer_if.sv
// Streaming handshake bundle shared by the sample input and byte output.
// The width parameter sizes tdata for each side.
interface hsadc_packetizer_if #(
  parameter int W = 8
);
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;
  logic         tlast;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/hsadc_packetizer.sv
// Packs 16-bit dual-channel ADC samples into framed byte packets:
// sync, sequence, sample bytes, XOR checksum (with tlast).
module hsadc_packetizer #(
  parameter int unsigned SAMPLES_PER_PACKET = 64,
  parameter logic [7:0]  SYNC_BYTE          = 8'hA5
) (
  input  logic                clk,
  input  logic                reset,
  hsadc_packetizer_if.slave   s_axis,
  hsadc_packetizer_if.master  m_axis,
  output logic [31:0]         packets_sent
);

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    SEQ,
    SAMPLE_HI,
    SAMPLE_LO,
    CHECKSUM
  } state_t;

  localparam logic [7:0] LAST_SAMPLE = 8'(SAMPLES_PER_PACKET);

  state_t     state;
  state_t     nxt;
  logic [7:0] dat_q;
  logic       vld_q;
  logic       lst_q;
  logic [7:0] seq;
  logic [7:0] csum;
  logic [7:0] lo_q;
  logic [7:0] cnt;
  logic       free;
  logic       hs;
  logic       ld;
  logic       ld_last;
  logic [7:0] ld_byte;
  logic       done;

  assign free = !vld_q || m_axis.tready;
  assign s_axis.tready = !reset && (state == SAMPLE_HI) && free;
  assign hs = s_axis.tvalid && s_axis.tready;
  // Checksum byte accepted downstream closes the packet.
  assign done = vld_q && lst_q && m_axis.tready;

  assign m_axis.tdata  = dat_q;
  assign m_axis.tvalid = vld_q;
  assign m_axis.tlast  = lst_q;

  always_comb begin
    nxt     = state;
    ld      = 1'b0;
    ld_last = 1'b0;
    ld_byte = dat_q;
    unique case (state)
      IDLE: begin
        if (s_axis.tvalid && free) begin
          ld      = 1'b1;
          ld_byte = SYNC_BYTE;
          nxt     = SYNC;
        end
      end
      SYNC: begin
        if (free) begin
          ld      = 1'b1;
          ld_byte = seq;
          nxt     = SEQ;
        end
      end
      SEQ: begin
        if (free) nxt = SAMPLE_HI;
      end
      SAMPLE_HI: begin
        if (hs) begin
          ld      = 1'b1;
          ld_byte = s_axis.tdata[15:8];
          nxt     = SAMPLE_LO;
        end
      end
      SAMPLE_LO: begin
        if (free) begin
          ld      = 1'b1;
          ld_byte = lo_q;
          nxt     = (cnt == LAST_SAMPLE) ? CHECKSUM : SAMPLE_HI;
        end
      end
      CHECKSUM: begin
        if (free) begin
          ld      = 1'b1;
          ld_last = 1'b1;
          ld_byte = csum;
          nxt     = IDLE;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      dat_q        <= '0;
      vld_q        <= 1'b0;
      lst_q        <= 1'b0;
      seq          <= '0;
      csum         <= '0;
      lo_q         <= '0;
      cnt          <= '0;
      packets_sent <= '0;
    end else begin
      state <= nxt;
      if (ld) begin
        dat_q <= ld_byte;
        vld_q <= 1'b1;
        lst_q <= ld_last;
      end else if (m_axis.tready) begin
        vld_q <= 1'b0;
        lst_q <= 1'b0;
      end
      if (ld && state == IDLE) begin
        csum <= SYNC_BYTE;
        cnt  <= '0;
      end else if (ld && !ld_last) begin
        csum <= csum ^ ld_byte;
      end
      if (hs) begin
        lo_q <= s_axis.tdata[7:0];
        cnt  <= cnt + 8'd1;
      end
      if (done) begin
        seq          <= seq + 8'd1;
        packets_sent <= packets_sent + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_hsadc_packetizer.sv
// Bench for hsadc_packetizer: directed tables plus randomized traffic
// scored against a packet-level model built from the framing rules.
module tb_hsadc_packetizer;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [31:0] pk2;
  logic [31:0] pk1;

  always #5 clk = ~clk;

  hsadc_packetizer_if #(.W(16)) s2 ();
  hsadc_packetizer_if #(.W(8))  m2 ();
  hsadc_packetizer_if #(.W(16)) s1 ();
  hsadc_packetizer_if #(.W(8))  m1 ();

  hsadc_packetizer #(
    .SAMPLES_PER_PACKET(2),
    .SYNC_BYTE(8'hA5)
  ) dut2 (
    .clk(clk),
    .reset(reset),
    .s_axis(s2),
    .m_axis(m2),
    .packets_sent(pk2)
  );

  hsadc_packetizer #(
    .SAMPLES_PER_PACKET(1),
    .SYNC_BYTE(8'hA5)
  ) dut1 (
    .clk(clk),
    .reset(reset),
    .s_axis(s1),
    .m_axis(m1),
    .packets_sent(pk1)
  );

  int errs = 0;
  int checks = 0;

  vec_t exp2[$];
  vec_t cap2[$];
  vec_t cap1[$];
  logic [7:0] mseq;
  int mpk;

  logic       st_pend = 1'b0;
  logic [7:0] st_d;
  logic       st_l;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // Capture accepted bytes and verify holds under backpressure.
  always @(posedge clk) begin
    if (reset) begin
      st_pend = 1'b0;
    end else begin
      if (st_pend) begin
        chk("stall_hold", {23'd0, m2.tvalid, m2.tlast, m2.tdata},
            {23'd0, 1'b1, st_l, st_d});
      end
      if (m2.tvalid && m2.tready) cap2.push_back('{m2.tdata, m2.tlast});
      if (m1.tvalid && m1.tready) cap1.push_back('{m1.tdata, m1.tlast});
      st_pend = m2.tvalid && !m2.tready;
      st_d = m2.tdata;
      st_l = m2.tlast;
    end
  end

  // Reference: framing computed from whole sample groups of two.
  task automatic model(input logic [15:0] smp[$]);
    for (int p = 0; p < smp.size() / 2; p++) begin
      logic [7:0] bytes[$];
      logic [7:0] x;
      bytes = {8'hA5, mseq};
      for (int k = 0; k < 2; k++) begin
        bytes.push_back(smp[2*p+k][15:8]);
        bytes.push_back(smp[2*p+k][7:0]);
      end
      x = 8'h00;
      foreach (bytes[j]) x ^= bytes[j];
      foreach (bytes[j]) exp2.push_back('{bytes[j], 1'b0});
      exp2.push_back('{x, 1'b1});
      mseq = mseq + 8'd1;
      mpk++;
    end
  endtask

  task automatic run2(input logic [15:0] smp[$], input int vpct,
                      input int rpct, input int stop_after, output int cyc);
    int i = 0;
    cyc = 0;
    while (cyc < 20000) begin
      if (stop_after > 0 && cap2.size() >= stop_after) break;
      if (stop_after == 0 && i >= smp.size() && cap2.size() >= exp2.size()) break;
      @(negedge clk);
      m2.tready = ($urandom_range(99) < rpct);
      if (i < smp.size()) begin
        s2.tvalid = ($urandom_range(99) < vpct);
        s2.tdata  = smp[i];
      end else begin
        s2.tvalid = 1'b0;
      end
      #1;
      if (s2.tvalid && s2.tready) i++;
      cyc++;
    end
    if (cyc >= 20000) chk("timeout", 1, 0);
    @(negedge clk);
    s2.tvalid = 1'b0;
    m2.tready = 1'b1;
  endtask

  task automatic cmp_stream(input string nm);
    chk({nm, "_len"}, cap2.size(), exp2.size());
    for (int k = 0; k < exp2.size() && k < cap2.size(); k++) begin
      chk({nm, "_data"}, {24'd0, cap2[k].data}, {24'd0, exp2[k].data});
      chk({nm, "_last"}, {31'd0, cap2[k].last}, {31'd0, exp2[k].last});
    end
    cap2.delete();
    exp2.delete();
  endtask

  task automatic cmp_table(input string nm, input vec_t tbl[7]);
    chk({nm, "_len"}, cap2.size(), 7);
    for (int k = 0; k < 7 && k < cap2.size(); k++) begin
      chk({nm, "_data"}, {24'd0, cap2[k].data}, {24'd0, tbl[k].data});
      chk({nm, "_last"}, {31'd0, cap2[k].last}, {31'd0, tbl[k].last});
    end
    cap2.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    s2.tvalid = 1'b0;
    s1.tvalid = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_tvalid", {31'd0, m2.tvalid}, 0);
    chk("rst_tdata", {24'd0, m2.tdata}, 0);
    chk("rst_tlast", {31'd0, m2.tlast}, 0);
    chk("rst_tready", {31'd0, s2.tready}, 0);
    chk("rst_pkts", pk2, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cap2.delete();
    cap1.delete();
    exp2.delete();
    mseq = 8'h00;
    mpk = 0;
  endtask

  initial begin
    vec_t tbl[7];
    vec_t tbl1[5];
    logic [15:0] smp[$];
    logic [15:0] base[$];
    int cyc;
    int n;

    tbl = '{'{8'hA5, 1'b0}, '{8'h00, 1'b0}, '{8'h12, 1'b0},
            '{8'h34, 1'b0}, '{8'h56, 1'b0}, '{8'h78, 1'b0},
            '{8'hAD, 1'b1}};
    tbl1 = '{'{8'hA5, 1'b0}, '{8'h00, 1'b0}, '{8'hFF, 1'b0},
             '{8'h00, 1'b0}, '{8'h5A, 1'b1}};
    base = {16'h1234, 16'h5678};

    s2.tdata = '0; s2.tvalid = 1'b0; s2.tlast = 1'b0; m2.tready = 1'b1;
    s1.tdata = '0; s1.tvalid = 1'b0; s1.tlast = 1'b0; m1.tready = 1'b1;

    do_reset();

    // Basic packet, full-rate downstream.
    model(base);
    run2(base, 100, 100, 0, cyc);
    cmp_table("basic", tbl);
    exp2.delete();
    chk("basic_pkts", pk2, 1);

    // Same stimulus under 50% backpressure after a fresh reset.
    do_reset();
    model(base);
    run2(base, 100, 50, 0, cyc);
    cmp_table("bp", tbl);
    exp2.delete();
    chk("bp_pkts", pk2, 1);

    // Random samples with input gaps and backpressure.
    smp.delete();
    for (int k = 0; k < 12; k++) smp.push_back(16'($urandom));
    model(smp);
    run2(smp, 40, 60, 0, cyc);
    cmp_stream("gaps");
    chk("gaps_pkts", pk2, 32'(mpk));

    // Reset after three bytes, then the basic packet again.
    smp = {16'hAAAA, 16'h5555};
    run2(smp, 100, 100, 3, cyc);
    do_reset();
    model(base);
    run2(base, 100, 100, 0, cyc);
    cmp_table("rstmid", tbl);
    exp2.delete();
    chk("rstmid_pkts", pk2, 1);

    // 257 back-to-back packets: sequence wrap and throughput.
    do_reset();
    smp.delete();
    for (int k = 0; k < 2 * 257; k++) smp.push_back(16'($urandom));
    model(smp);
    run2(smp, 100, 100, 0, cyc);
    n = cap2.size();
    chk("wrap_seq_255", {24'd0, (n > 255*7+1) ? cap2[255*7+1].data : 8'hxx}, 32'hFF);
    chk("wrap_seq_256", {24'd0, (n > 256*7+1) ? cap2[256*7+1].data : 8'hxx}, 32'h00);
    cmp_stream("wrap");
    chk("wrap_pkts", pk2, 257);
    chk("wrap_rate", {31'd0, cyc <= 257 * 8 + 8}, 1);

    // Single-sample packets on the second instance.
    @(negedge clk);
    s1.tdata = 16'hFF00;
    s1.tvalid = 1'b1;
    cyc = 0;
    while (cyc < 100) begin
      @(negedge clk);
      #1;
      if (s1.tready) begin
        @(negedge clk);
        s1.tvalid = 1'b0;
        break;
      end
      cyc++;
    end
    s1.tvalid = 1'b0;
    cyc = 0;
    while (cap1.size() < 5 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("one_len", cap1.size(), 5);
    for (int k = 0; k < 5 && k < cap1.size(); k++) begin
      chk("one_data", {24'd0, cap1[k].data}, {24'd0, tbl1[k].data});
      chk("one_last", {31'd0, cap1[k].last}, {31'd0, tbl1[k].last});
    end
    chk("one_pkts", pk1, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
